evt_word_decoder: RTL and testbench

Receive-side decoder for the hierarchical arbiter's event word stream. Accepts 32-bit words produced by the top-level arbiter packer, tracks the timestamp time base and rebuilds full events (row, column, polarity, 34-bit timestamp) on a valid/ready output. Sits between the readout link and the downstream event consumer (FIFO or host DMA).

---
 rtl/evt_word_decoder.sv | 218 +++++++++++++++++++++
 tb/tb_evt_word_decoder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/evt_word_decoder.sv
// -----------------------------------------------------------------------------
// evt_word_decoder
//
// Receive-side decoder for the hierarchical arbiter's 32-bit event word stream.
//
// The decoder does three things:
//   - tracks the timestamp time base from TIME_HIGH and SYNC words;
//   - rebuilds full events (row, column, polarity, 34-bit timestamp) from
//     EVENT words;
//   - presents those events on a single-entry valid/ready output register.
//
// Word format (type in bits [31:30]):
//   00 IDLE       consumed and ignored
//   01 EVENT      pol [29:28], row [27:17], col [16:6], ts_low [5:0]
//   10 TIME_HIGH  ts_high [27:0] = timestamp[33:6]
//   11 SYNC       clears the time base and waits for a new TIME_HIGH
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   word_i/word_valid_i  encoded input word and its valid
//   word_ready_o         word is accepted this cycle when valid & ready
//   evt_row_o/col/pol/ts rebuilt event fields
//   evt_valid_o          event valid
//   evt_ready_i          consumer accepts event
//   synced_o             time base held (state RUN)
//   err_o                one-cycle pulse per dropped or illegal word
//   evt_cnt_o            decoded event count (stats build only, else 0)
//   drop_cnt_o           dropped word count (stats build only, else 0)
//
// Optional feature macro: EVT_DEC_STATS_EN enables the saturating
// evt_cnt_o / drop_cnt_o counters. Without it both outputs are tied to 0.
// -----------------------------------------------------------------------------
module evt_word_decoder #(
    parameter int WIDTH    = 32,
    parameter int ROW_ADD  = 11,
    parameter int COL_ADD  = 11,
    parameter int POLARITY = 2,
    parameter int SIZE     = 34,
    parameter int ROWS1    = 64,
    parameter int COLS1    = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [WIDTH-1:0]    word_i,
    input  logic                word_valid_i,
    output logic                word_ready_o,
    output logic [ROW_ADD-1:0]  evt_row_o,
    output logic [COL_ADD-1:0]  evt_col_o,
    output logic [POLARITY-1:0] evt_pol_o,
    output logic [SIZE-1:0]     evt_ts_o,
    output logic                evt_valid_o,
    input  logic                evt_ready_i,
    output logic                synced_o,
    output logic                err_o,
    output logic [31:0]         evt_cnt_o,
    output logic [31:0]         drop_cnt_o
);

    // The low six timestamp bits travel in every EVENT word; the rest is
    // the time base carried by TIME_HIGH.
    localparam int TSL_W = 6;
    localparam int TSH_W = SIZE - TSL_W;

    typedef enum logic {
        WAIT_TIME = 1'b0,
        RUN       = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [TSH_W-1:0]    ts_high_q, ts_high_d;
    logic                evt_valid_q, evt_valid_d;
    logic [ROW_ADD-1:0]  evt_row_q, evt_row_d;
    logic [COL_ADD-1:0]  evt_col_q, evt_col_d;
    logic [POLARITY-1:0] evt_pol_q, evt_pol_d;
    logic [SIZE-1:0]     evt_ts_q, evt_ts_d;
    logic                err_q, err_d;

    logic                accept;
    logic [1:0]          word_type;
    logic [ROW_ADD-1:0]  word_row;
    logic [COL_ADD-1:0]  word_col;
    logic [POLARITY-1:0] word_pol;
    logic [TSL_W-1:0]    word_ts_low;
    logic [TSH_W-1:0]    word_ts_high;
    logic                in_range;

    // Every word type obeys the same ready rule, so a stalled consumer also
    // holds back TIME_HIGH/SYNC words; this keeps time-base updates ordered
    // with respect to the events they apply to.
    assign word_ready_o = !evt_valid_q | evt_ready_i;
    assign accept       = word_valid_i & word_ready_o;

    assign word_type    = word_i[31:30];
    assign word_pol     = word_i[28 +: POLARITY];
    assign word_row     = word_i[17 +: ROW_ADD];
    assign word_col     = word_i[6 +: COL_ADD];
    assign word_ts_low  = word_i[TSL_W-1:0];
    assign word_ts_high = word_i[TSH_W-1:0];
    assign in_range     = (word_row < ROW_ADD'(ROWS1)) && (word_col < COL_ADD'(COLS1));

    // Next-state logic: time base tracking, event reconstruction and the
    // output register handshake. Draining and refilling in the same cycle
    // works because the drain clears valid first and a load then sets it.
    always_comb begin
        state_d     = state_q;
        ts_high_d   = ts_high_q;
        evt_valid_d = evt_valid_q;
        evt_row_d   = evt_row_q;
        evt_col_d   = evt_col_q;
        evt_pol_d   = evt_pol_q;
        evt_ts_d    = evt_ts_q;
        err_d       = 1'b0;

        if (evt_valid_q && evt_ready_i) begin
            evt_valid_d = 1'b0;
        end

        if (accept) begin
            case (word_type)
                2'b00: begin
                end
                2'b01: begin
                    if (state_q == WAIT_TIME || !in_range) begin
                        err_d = 1'b1;
                    end else begin
                        evt_valid_d = 1'b1;
                        evt_row_d   = word_row;
                        evt_col_d   = word_col;
                        evt_pol_d   = word_pol;
                        evt_ts_d    = {ts_high_q, word_ts_low};
                    end
                end
                2'b10: begin
                    // A backwards time base is flagged but still adopted so
                    // the stream keeps decoding against the sender's view.
                    if (state_q == RUN && word_ts_high < ts_high_q) begin
                        err_d = 1'b1;
                    end
                    ts_high_d = word_ts_high;
                    state_d   = RUN;
                end
                2'b11: begin
                    ts_high_d = '0;
                    state_d   = WAIT_TIME;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= WAIT_TIME;
            ts_high_q   <= '0;
            evt_valid_q <= 1'b0;
            evt_row_q   <= '0;
            evt_col_q   <= '0;
            evt_pol_q   <= '0;
            evt_ts_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ts_high_q   <= ts_high_d;
            evt_valid_q <= evt_valid_d;
            evt_row_q   <= evt_row_d;
            evt_col_q   <= evt_col_d;
            evt_pol_q   <= evt_pol_d;
            evt_ts_q    <= evt_ts_d;
            err_q       <= err_d;
        end
    end

    assign evt_valid_o = evt_valid_q;
    assign evt_row_o   = evt_row_q;
    assign evt_col_o   = evt_col_q;
    assign evt_pol_o   = evt_pol_q;
    assign evt_ts_o    = evt_ts_q;
    assign synced_o    = (state_q == RUN);
    assign err_o       = err_q;

`ifdef EVT_DEC_STATS_EN
    logic [31:0] evt_cnt_q, evt_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;
    logic        evt_load;

    // While ready is high the output register can only become valid through
    // a fresh load, so this identifies exactly one event per load.
    assign evt_load = evt_valid_d & word_ready_o;

    // Saturating counters: they stick at all-ones rather than wrapping.
    always_comb begin
        evt_cnt_d  = evt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (evt_load && evt_cnt_q != 32'hFFFF_FFFF) begin
            evt_cnt_d = evt_cnt_q + 32'd1;
        end
        if (err_d && drop_cnt_q != 32'hFFFF_FFFF) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            evt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            evt_cnt_q  <= evt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign evt_cnt_o  = evt_cnt_q;
    assign drop_cnt_o = drop_cnt_q;
`else
    assign evt_cnt_o  = '0;
    assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_evt_word_decoder.sv
// -----------------------------------------------------------------------------
// tb_evt_word_decoder
//
// Self-checking bench for evt_word_decoder. A cycle-level reference model
// built from the word rules (time base, event reconstruction, single-entry
// output, error pulses, counters) predicts the DUT outputs each cycle.
// Directed scenarios are followed by a long randomized stream.
// -----------------------------------------------------------------------------
module tb_evt_word_decoder;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] word_i;
    logic        word_valid_i;
    logic        word_ready_o;
    logic [10:0] evt_row_o;
    logic [10:0] evt_col_o;
    logic [1:0]  evt_pol_o;
    logic [33:0] evt_ts_o;
    logic        evt_valid_o;
    logic        evt_ready_i;
    logic        synced_o;
    logic        err_o;
    logic [31:0] evt_cnt_o;
    logic [31:0] drop_cnt_o;

    evt_word_decoder dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .word_i       (word_i),
        .word_valid_i (word_valid_i),
        .word_ready_o (word_ready_o),
        .evt_row_o    (evt_row_o),
        .evt_col_o    (evt_col_o),
        .evt_pol_o    (evt_pol_o),
        .evt_ts_o     (evt_ts_o),
        .evt_valid_o  (evt_valid_o),
        .evt_ready_i  (evt_ready_i),
        .synced_o     (synced_o),
        .err_o        (err_o),
        .evt_cnt_o    (evt_cnt_o),
        .drop_cnt_o   (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int check_count = 0;
    int error_count = 0;

    // Reference model state.
    bit     m_valid;
    int     m_row, m_col, m_pol;
    longint m_ts;
    bit     m_err;
    bit     m_synced;
    longint m_ts_high;
    longint m_evt_cnt;
    longint m_drop_cnt;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic resetModel();
        m_valid = 0; m_row = 0; m_col = 0; m_pol = 0; m_ts = 0;
        m_err = 0; m_synced = 0; m_ts_high = 0; m_evt_cnt = 0; m_drop_cnt = 0;
    endtask

    function automatic logic [31:0] mkEvent(input int pol, input int row, input int col, input int tsl);
        logic [1:0]  p = pol[1:0];
        logic [10:0] r = row[10:0];
        logic [10:0] c = col[10:0];
        logic [5:0]  t = tsl[5:0];
        return {2'b01, p, r, c, t};
    endfunction

    function automatic logic [31:0] mkTime(input longint th);
        logic [27:0] t = th[27:0];
        return {2'b10, 2'b00, t};
    endfunction

    function automatic logic [31:0] mkSync();
        return 32'hC000_0000;
    endfunction

    task automatic verifyState(input logic r);
        checkOutput("evt_valid", evt_valid_o, m_valid);
        checkOutput("word_ready", word_ready_o, (!m_valid) || r);
        checkOutput("err", err_o, m_err);
        checkOutput("synced", synced_o, m_synced);
        if (m_valid) begin
            checkOutput("evt_row", evt_row_o, m_row);
            checkOutput("evt_col", evt_col_o, m_col);
            checkOutput("evt_pol", evt_pol_o, m_pol);
            checkOutput("evt_ts", evt_ts_o, m_ts);
        end
`ifdef EVT_DEC_STATS_EN
        checkOutput("evt_cnt", evt_cnt_o, m_evt_cnt);
        checkOutput("drop_cnt", drop_cnt_o, m_drop_cnt);
`else
        checkOutput("evt_cnt", evt_cnt_o, 0);
        checkOutput("drop_cnt", drop_cnt_o, 0);
`endif
    endtask

    // One clock cycle: drive inputs just after a falling edge, check the
    // registered outputs, advance the model by the word rules, then return
    // at the next falling edge with the new state visible.
    task automatic applyStimulus(input logic [31:0] w, input logic v, input logic r, output bit accepted);
        int     row, col;
        longint th;
        word_i       = w;
        word_valid_i = v;
        evt_ready_i  = r;
        #1;
        verifyState(r);
        accepted = v && (!m_valid || r);
        if (m_valid && r) m_valid = 0;
        m_err = 0;
        if (accepted) begin
            case (w[31:30])
                2'b01: begin
                    row = int'(w[27:17]);
                    col = int'(w[16:6]);
                    if (!m_synced || row >= 64 || col >= 64) begin
                        m_err = 1;
                        m_drop_cnt++;
                    end else begin
                        m_valid = 1;
                        m_row   = row;
                        m_col   = col;
                        m_pol   = int'(w[29:28]);
                        m_ts    = m_ts_high * 64 + longint'(w[5:0]);
                        m_evt_cnt++;
                    end
                end
                2'b10: begin
                    th = longint'(w[27:0]);
                    if (m_synced && th < m_ts_high) begin
                        m_err = 1;
                        m_drop_cnt++;
                    end
                    m_ts_high = th;
                    m_synced  = 1;
                end
                2'b11: begin
                    m_ts_high = 0;
                    m_synced  = 0;
                end
                default: ;
            endcase
        end
        @(negedge clk_i);
    endtask

    initial begin
        bit          acc;
        int          sent;
        int          cyc;
        int          kind;
        longint      th;
        logic [31:0] w;

        rst_ni       = 1'b0;
        word_i       = '0;
        word_valid_i = 1'b0;
        evt_ready_i  = 1'b0;
        resetModel();
        repeat (2) @(negedge clk_i);

        // Reset values
        checkOutput("rst_valid", evt_valid_o, 0);
        checkOutput("rst_row", evt_row_o, 0);
        checkOutput("rst_col", evt_col_o, 0);
        checkOutput("rst_pol", evt_pol_o, 0);
        checkOutput("rst_ts", evt_ts_o, 0);
        checkOutput("rst_synced", synced_o, 0);
        checkOutput("rst_err", err_o, 0);
        rst_ni = 1'b1;

        // EVENT before any time base is dropped
        $display("[TB] event before time base");
        applyStimulus(mkEvent(1, 3, 5, 0), 1, 1, acc);
        checkOutput("early_err", err_o, 1);
        checkOutput("early_valid", evt_valid_o, 0);
        checkOutput("early_synced", synced_o, 0);
`ifdef EVT_DEC_STATS_EN
        checkOutput("early_drop_cnt", drop_cnt_o, 1);
`endif

        // Basic reconstruction
        $display("[TB] basic event reconstruction");
        applyStimulus(mkTime(28'h0000123), 1, 1, acc);
        checkOutput("th_synced", synced_o, 1);
        applyStimulus(mkEvent(1, 10, 20, 6'h2A), 1, 1, acc);
        checkOutput("basic_valid", evt_valid_o, 1);
        checkOutput("basic_ts", evt_ts_o, 34'h48EA);
        checkOutput("basic_row", evt_row_o, 10);
        checkOutput("basic_col", evt_col_o, 20);
        checkOutput("basic_pol", evt_pol_o, 1);

        // Back-to-back events with the consumer stalled for three cycles
        $display("[TB] back-to-back with stall");
        sent = 0;
        cyc  = 0;
        while (sent < 8 && cyc < 50) begin
            applyStimulus(mkEvent(sent & 3, sent + 1, 2 * sent, sent), 1, cyc >= 3, acc);
            if (acc) sent++;
            cyc++;
        end
        checkOutput("b2b_sent", sent, 8);
        applyStimulus('0, 0, 1, acc);

        // Row out of range in RUN
        $display("[TB] row out of range");
        applyStimulus(mkEvent(0, 64, 0, 0), 1, 1, acc);
        checkOutput("range_err", err_o, 1);
        checkOutput("range_valid", evt_valid_o, 0);

        // Time base going backwards, then SYNC
        $display("[TB] backwards time base and sync");
        applyStimulus(mkSync(), 1, 1, acc);
        applyStimulus(mkTime(5), 1, 1, acc);
        applyStimulus(mkTime(4), 1, 1, acc);
        checkOutput("back_err", err_o, 1);
        applyStimulus(mkEvent(2, 1, 1, 0), 1, 1, acc);
        checkOutput("back_ts", evt_ts_o, 34'h100);
        applyStimulus(mkSync(), 1, 1, acc);
        checkOutput("sync_synced", synced_o, 0);
        applyStimulus(mkEvent(2, 1, 1, 0), 1, 1, acc);
        checkOutput("sync_drop_err", err_o, 1);

        // Reset mid-stream with an event pending
        $display("[TB] reset with pending event");
        applyStimulus(mkTime(7), 1, 1, acc);
        applyStimulus(mkEvent(3, 9, 9, 9), 1, 0, acc);
        checkOutput("pre_rst_valid", evt_valid_o, 1);
        word_valid_i = 1'b0;
        rst_ni       = 1'b0;
        #1;
        checkOutput("mid_rst_valid", evt_valid_o, 0);
        checkOutput("mid_rst_synced", synced_o, 0);
        checkOutput("mid_rst_evt_cnt", evt_cnt_o, 0);
        checkOutput("mid_rst_drop_cnt", drop_cnt_o, 0);
        resetModel();
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Randomized stream
        $display("[TB] randomized stream");
        for (int i = 0; i < 3000; i++) begin
            kind = int'($urandom_range(0, 99));
            if (!m_synced && kind < 50) kind = 60;
            if (kind < 10) begin
                w = $urandom & 32'h3FFF_FFFF;
            end else if (kind < 55) begin
                w = mkEvent(int'($urandom_range(0, 3)), int'($urandom_range(0, 70)),
                            int'($urandom_range(0, 70)), int'($urandom_range(0, 63)));
            end else if (kind < 95) begin
                if ($urandom_range(0, 9) == 0 && m_ts_high > 0)
                    th = m_ts_high - 1;
                else
                    th = m_ts_high + longint'($urandom_range(0, 3));
                w = mkTime(th);
            end else begin
                w = mkSync();
            end
            applyStimulus(w, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, acc);
        end
        applyStimulus('0, 0, 1, acc);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
